kamacore_regfile: RTL

//  Architectural integer register file; the receiving end of the writeback port.

---
 rtl/kamacore_pkg.sv | 16 +
 rtl/kamacore_regfile_if.sv | 31 +++
 rtl/kamacore_regfile_scoreboard.sv | 77 +++++++
 rtl/kamacore_regfile.sv | 62 ++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared widths and types for the kamacore integer register file slice.
package kamacore_pkg;
    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;
    localparam int PEND_WIDTH     = 2;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [CPU_WIDTH-1:0]      word_t;
    typedef logic [PEND_WIDTH-1:0]     pend_cnt_t;

    // True when an enabled write targets a non-zero register equal to addr.
    function automatic logic addr_hit(input logic we, input reg_addr_t wa, input reg_addr_t addr);
        return we && (wa == addr) && (addr != '0);
    endfunction
endpackage

// File: rtl/kamacore_regfile_if.sv
// Decode/writeback bundle of the register file: master drives, slave is the regfile.
interface kamacore_regfile_if;
    import kamacore_pkg::*;

    reg_addr_t rs1_a;
    reg_addr_t rs2_a;
    word_t     rs1_data;
    word_t     rs2_data;
    logic      rs1_pending;
    logic      rs2_pending;
    logic      issue_we;
    reg_addr_t issue_rd_a;
    logic      issue_ready;
    logic      flush;
    logic      writeback_rd_we;
    reg_addr_t writeback_rd_a;
    word_t     writeback_rd_data;
    logic      wb_underflow;

    modport master (
        output rs1_a, rs2_a, issue_we, issue_rd_a, flush,
               writeback_rd_we, writeback_rd_a, writeback_rd_data,
        input  rs1_data, rs2_data, rs1_pending, rs2_pending, issue_ready, wb_underflow
    );

    modport slave (
        input  rs1_a, rs2_a, issue_we, issue_rd_a, flush,
               writeback_rd_we, writeback_rd_a, writeback_rd_data,
        output rs1_data, rs2_data, rs1_pending, rs2_pending, issue_ready, wb_underflow
    );
endinterface

// File: rtl/kamacore_regfile_scoreboard.sv
// Per-register pending-writer counters, issue_ready, pending flags and the sticky underflow flag.
// KAMACORE_REGFILE_BYPASS_EN credits a same-cycle writeback in the pending flags.
module kamacore_regfile_scoreboard
    import kamacore_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int PEND_WIDTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      issue_we,
    input  reg_addr_t issue_rd_a,
    input  logic      wb_we,
    input  reg_addr_t wb_a,
    input  reg_addr_t rs1_a,
    input  reg_addr_t rs2_a,
    output logic      rs1_pending,
    output logic      rs2_pending,
    output logic      issue_ready,
    output logic      wb_underflow
);
    typedef logic [PEND_WIDTH-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    cnt_t cnt_reg  [NUM_REGS];
    cnt_t cnt_next [NUM_REGS];
    logic underflow_reg;
    logic issue_fire;
    logic underflow_set;

    // Readiness looks only at the registered count; a same-cycle retire is not credited.
    assign issue_ready   = (issue_rd_a == '0) || (cnt_reg[issue_rd_a] != CNT_MAX);
    assign issue_fire    = issue_we && issue_ready && (issue_rd_a != '0);
    assign underflow_set = !flush && wb_we && (wb_a != '0) && (cnt_reg[wb_a] == '0)
                           && !(issue_fire && (issue_rd_a == wb_a));
    assign wb_underflow  = underflow_reg;

    assign cnt_next[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            logic issue_hit;
            logic wb_hit;
            assign issue_hit = issue_fire && (issue_rd_a == reg_addr_t'(gi));
            assign wb_hit    = wb_we && (wb_a == reg_addr_t'(gi));
            // Flush wipes everything, then a same-cycle issue re-registers its producer.
            assign cnt_next[gi] = flush                  ? (issue_hit ? cnt_t'(1) : '0) :
                                  (issue_hit && wb_hit)  ? cnt_reg[gi] :
                                  issue_hit              ? cnt_reg[gi] + cnt_t'(1) :
                                  (wb_hit && cnt_reg[gi] != '0) ? cnt_reg[gi] - cnt_t'(1) :
                                  cnt_reg[gi];
        end
    endgenerate

`ifdef KAMACORE_REGFILE_BYPASS_EN
    assign rs1_pending = (cnt_reg[rs1_a] - cnt_t'(addr_hit(wb_we, wb_a, rs1_a))) != '0;
    assign rs2_pending = (cnt_reg[rs2_a] - cnt_t'(addr_hit(wb_we, wb_a, rs2_a))) != '0;
`else
    assign rs1_pending = cnt_reg[rs1_a] != '0;
    assign rs2_pending = cnt_reg[rs2_a] != '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_reg[i] <= '0;
            end
            underflow_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (underflow_set) begin
                underflow_reg <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/kamacore_regfile.sv
// Architectural integer register file: data array, two combinational read ports, scoreboard.
// KAMACORE_REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
module kamacore_regfile
    import kamacore_pkg::*;
#(
    parameter int NUM_REGS   = kamacore_pkg::NUM_REGS,
    parameter int PEND_WIDTH = kamacore_pkg::PEND_WIDTH
) (
    input logic               clk,
    input logic               rst,
    kamacore_regfile_if.slave rf
);
    word_t     regs_reg [NUM_REGS];
    reg_addr_t rd_a     [2];
    word_t     rd_data  [2];

    assign rd_a[0]     = rf.rs1_a;
    assign rd_a[1]     = rf.rs2_a;
    assign rf.rs1_data = rd_data[0];
    assign rf.rs2_data = rd_data[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rf.writeback_rd_we && (rf.writeback_rd_a != '0)) begin
            regs_reg[rf.writeback_rd_a] <= rf.writeback_rd_data;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef KAMACORE_REGFILE_BYPASS_EN
            assign rd_data[gi] = addr_hit(rf.writeback_rd_we, rf.writeback_rd_a, rd_a[gi])
                                 ? rf.writeback_rd_data
                                 : ((rd_a[gi] == '0) ? '0 : regs_reg[rd_a[gi]]);
`else
            assign rd_data[gi] = (rd_a[gi] == '0) ? '0 : regs_reg[rd_a[gi]];
`endif
        end
    endgenerate

    kamacore_regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .flush        (rf.flush),
        .issue_we     (rf.issue_we),
        .issue_rd_a   (rf.issue_rd_a),
        .wb_we        (rf.writeback_rd_we),
        .wb_a         (rf.writeback_rd_a),
        .rs1_a        (rf.rs1_a),
        .rs2_a        (rf.rs2_a),
        .rs1_pending  (rf.rs1_pending),
        .rs2_pending  (rf.rs2_pending),
        .issue_ready  (rf.issue_ready),
        .wb_underflow (rf.wb_underflow)
    );
endmodule
